// File: rtl/id_stage.sv
// id_stage: RV32I decode stage for the OP / OP-IMM integer subset.
// A two-entry FIFO (head + skid) of decoded entries sits between fetch and EX.
// inst_ready_o comes from a flop, so fetch never sees a combinational path from
// out_ready_i. Source operands are resolved when the head entry is presented to
// EX, not when it is accepted, so that EX-stage bypass data is always current.
// Optional feature: define ILLEGAL_TRAP_EN to flag illegal head entries on
// illegal_o. Without it illegal_o is tied low and illegal words simply issue as
// NOPs.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    output logic        inst_ready_o,
    output logic [4:0]  raddr1_o,
    output logic [4:0]  raddr2_o,
    input  logic [31:0] rdata1_i,
    input  logic [31:0] rdata2_i,
    input  logic        fwd_wreg_i,
    input  logic [4:0]  fwd_wd_i,
    input  logic [31:0] fwd_wdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [6:0]  aluop_o,
    output logic [2:0]  alufun_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o,
    output logic [31:0] imm_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // One decoded instruction. rs1/rs2 are kept instead of operand values
    // because operands are looked up only when the entry reaches the head.
    typedef struct packed {
        logic [6:0]  aluop;
        logic [2:0]  alufun;
        logic [31:0] imm;
        logic [4:0]  wd;
        logic        wreg;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
`ifdef ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } entry_t;

    // Decode a raw word into an entry. Anything outside the supported OP /
    // OP-IMM encodings (including unknown opcodes) becomes a NOP: no ALU op,
    // no immediate, no register reads and no write-back.
    function automatic entry_t decode(input logic [31:0] inst);
        entry_t      e;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        is_opimm;
        logic        is_op;
        logic        legal;
        opc      = inst[6:0];
        f7       = inst[31:25];
        f3       = inst[14:12];
        is_opimm = (opc == OPC_OPIMM);
        is_op    = (opc == OPC_OP);
        legal    = 1'b0;
        if (is_opimm) begin
            case (f3)
                3'b001:  legal = (f7 == F7_ZERO);
                3'b101:  legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                default: legal = 1'b1;
            endcase
        end else if (is_op) begin
            legal = (f7 == F7_ZERO) ||
                    ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end

        e    = '0;
        e.wd = inst[11:7];
        if (legal) begin
            e.aluop  = opc;
            e.alufun = f3;
            e.rs1    = inst[19:15];
            e.wreg   = (inst[11:7] != 5'd0);
            if (is_opimm) begin
                // I-type immediate, sign-extended; rs2 is not read.
                e.imm = 32'($signed(inst[31:20]));
                e.rs2 = 5'd0;
            end else begin
                // Register op: zero-extended funct7/rs2 field, so imm[10]
                // carries inst[30] (SUB / SRA select) to the ALU.
                e.imm = {20'd0, inst[31:20]};
                e.rs2 = inst[24:20];
            end
        end
`ifdef ILLEGAL_TRAP_EN
        e.illegal = !legal;
`endif
        return e;
    endfunction

    // Operand lookup: x0 reads as zero, a matching EX result wins over the
    // register file.
    function automatic logic [31:0] resolve(
        input logic [4:0]  addr,
        input logic [31:0] rdata,
        input logic        fwd_wreg,
        input logic [4:0]  fwd_wd,
        input logic [31:0] fwd_wdata
    );
        logic [31:0] v;
        if (addr == 5'd0) begin
            v = 32'd0;
        end else if (fwd_wreg && (fwd_wd == addr)) begin
            v = fwd_wdata;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    state_t state_q, state_d;
    logic   ready_q;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    logic   push;
    logic   pop;

    // Handshakes are masked while rst is high so nothing completes in the
    // reset cycle.
    assign inst_ready_o = ready_q && !rst;
    assign out_valid_o  = (state_q != S_EMPTY) && !rst;
    assign push         = inst_valid_i && inst_ready_o;
    assign pop          = out_valid_o && out_ready_i;
    assign new_entry    = decode(inst_i);

    // Control state: occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_TWO);
        end
    end

    // Entry storage; validity is carried by state_q, so no reset is needed.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

    // Next occupancy and entry movement; flush overrides any push or pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        head_d  = new_entry;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_d  = new_entry;
                        state_d = S_ONE;
                    end else if (push) begin
                        skid_d  = new_entry;
                        state_d = S_TWO;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // ready_q is low here, so only a pop can happen.
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Present the head entry with operands resolved now; everything reads
    // zero while no entry is offered.
    always_comb begin
        raddr1_o  = 5'd0;
        raddr2_o  = 5'd0;
        aluop_o   = 7'd0;
        alufun_o  = 3'd0;
        reg1_o    = 32'd0;
        reg2_o    = 32'd0;
        imm_o     = 32'd0;
        wd_o      = 5'd0;
        wreg_o    = 1'b0;
        illegal_o = 1'b0;
        if (out_valid_o) begin
            raddr1_o = head_q.rs1;
            raddr2_o = head_q.rs2;
            aluop_o  = head_q.aluop;
            alufun_o = head_q.alufun;
            reg1_o   = resolve(head_q.rs1, rdata1_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
            reg2_o   = resolve(head_q.rs2, rdata2_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
            imm_o    = head_q.imm;
            wd_o     = head_q.wd;
            wreg_o   = head_q.wreg;
`ifdef ILLEGAL_TRAP_EN
            illegal_o = head_q.illegal;
`endif
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus randomized traffic for id_stage.
// The reference keeps the buffered raw instruction words in a queue and
// derives every expected output from the RV32I encoding rules.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic        inst_ready_o;
    logic [4:0]  raddr1_o, raddr2_o;
    logic [31:0] rdata1_i, rdata2_i;
    logic        fwd_wreg_i;
    logic [4:0]  fwd_wd_i;
    logic [31:0] fwd_wdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [6:0]  aluop_o;
    logic [2:0]  alufun_o;
    logic [31:0] reg1_o, reg2_o, imm_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [31:0] rf [32];
    logic [31:0] q [$];

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    assign rdata1_i = rf[raddr1_o];
    assign rdata2_i = rf[raddr2_o];

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .inst_ready_o (inst_ready_o),
        .raddr1_o     (raddr1_o),
        .raddr2_o     (raddr2_o),
        .rdata1_i     (rdata1_i),
        .rdata2_i     (rdata2_i),
        .fwd_wreg_i   (fwd_wreg_i),
        .fwd_wd_i     (fwd_wd_i),
        .fwd_wdata_i  (fwd_wdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .aluop_o      (aluop_o),
        .alufun_o     (alufun_o),
        .reg1_o       (reg1_o),
        .reg2_o       (reg2_o),
        .imm_o        (imm_o),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .illegal_o    (illegal_o)
    );

    // Value a source register must present: x0 is zero, the EX result wins.
    function automatic logic [31:0] operand(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (fwd_wreg_i && fwd_wd_i == a) return fwd_wdata_i;
        return rf[a];
    endfunction

    // Reference decode of one raw word from the RV32I encoding rules.
    task automatic ref_decode(input logic [31:0] w,
                              output logic [6:0] aop, output logic [2:0] fun,
                              output logic [31:0] imm, output logic [4:0] r1,
                              output logic [4:0] r2, output logic wr,
                              output logic ill);
        int opc, f3, f7, field, v;
        opc   = int'(w[6:0]);
        f3    = int'(w[14:12]);
        f7    = int'(w[31:25]);
        field = int'(w[31:20]);
        ill   = 1'b1;
        if (opc == 19) begin
            if (f3 == 1)      ill = (f7 != 0);
            else if (f3 == 5) ill = !(f7 == 0 || f7 == 32);
            else              ill = 1'b0;
        end else if (opc == 51) begin
            ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
        end
        aop = 0; fun = 0; imm = 0; r1 = 0; r2 = 0; wr = 0;
        if (!ill) begin
            aop = 7'(opc);
            fun = 3'(f3);
            r1  = w[19:15];
            wr  = (w[11:7] != 0);
            if (opc == 19) begin
                v   = (field >= 2048) ? field - 4096 : field;
                imm = 32'(v);
            end else begin
                imm = 32'(field);
                r2  = w[24:20];
            end
        end
    endtask

    // Occupancy model: flush or reset empties it, otherwise pop then push.
    always @(posedge clk) begin : model_update
        bit do_pop, do_push;
        if (rst || flush_i) begin
            q.delete();
        end else begin
            do_pop  = (q.size() > 0) && out_ready_i;
            do_push = inst_valid_i && (q.size() < 2);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(inst_i);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        logic [6:0]  aop;
        logic [2:0]  fun;
        logic [31:0] imm, r1v, r2v;
        logic [4:0]  r1, r2, wd;
        logic        wr, ill, vld, rdy;
        logic [124:0] exp_v, act_v;
        if (cmp_en) begin
            vld = !rst && (q.size() > 0);
            rdy = !rst && (q.size() < 2);
            aop = 0; fun = 0; imm = 0; r1 = 0; r2 = 0; wr = 0; ill = 0; wd = 0;
            r1v = 0; r2v = 0;
            if (vld) begin
                ref_decode(q[0], aop, fun, imm, r1, r2, wr, ill);
                wd  = q[0][11:7];
                r1v = operand(r1);
                r2v = operand(r2);
                ill = ill && TRAP;
            end
            exp_v = {vld, rdy, r1, r2, aop, fun, r1v, r2v, imm, wd, wr, ill};
            act_v = {out_valid_o, inst_ready_o, raddr1_o, raddr2_o, aluop_o,
                     alufun_o, reg1_o, reg2_o, imm_o, wd_o, wreg_o, illegal_o};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        int k, j;
        k = $urandom_range(0, 9);
        if (k < 4)      op = 7'b0010011;
        else if (k < 8) op = 7'b0110011;
        else            op = 7'($urandom);
        j = $urandom_range(0, 3);
        if (j == 0)      f7 = 7'd0;
        else if (j == 1) f7 = 7'b0100000;
        else             f7 = 7'($urandom);
        f3  = 3'($urandom);
        rd  = 5'($urandom);
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    localparam logic [31:0] I_ADDI = 32'hFFF08293;  // addi x5,x1,-1
    localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub  x3,x1,x2
    localparam logic [31:0] I_ADD0 = 32'h00100013;  // addi x0,x0,1

    initial begin
        rst = 1; flush_i = 0; inst_valid_i = 0; inst_i = 0; out_ready_i = 0;
        fwd_wreg_i = 0; fwd_wd_i = 0; fwd_wdata_i = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'd10;
        rf[2] = 32'd20;

        step();
        cmp_en = 1;
        step();
        rst = 0;
        #1;
        chk("reset_out_valid", 32'(out_valid_o), 0);
        chk("reset_inst_ready", 32'(inst_ready_o), 1);
        chk("reset_data", {reg1_o[15:0], imm_o[7:0], aluop_o, wreg_o}, 0);

        // ADDI x5,x1,-1 with x1=10
        inst_valid_i = 1; inst_i = I_ADDI; out_ready_i = 1;
        step();
        inst_valid_i = 0;
        #1;
        chk("addi_valid", 32'(out_valid_o), 1);
        chk("addi_aluop", 32'(aluop_o), 32'h13);
        chk("addi_alufun", 32'(alufun_o), 0);
        chk("addi_reg1", reg1_o, 10);
        chk("addi_imm", imm_o, 32'hFFFFFFFF);
        chk("addi_wd", 32'(wd_o), 5);
        chk("addi_wreg", 32'(wreg_o), 1);
        step();

        // SUB x3,x1,x2 with x2 bypassed from EX
        inst_valid_i = 1; inst_i = I_SUB;
        fwd_wreg_i = 1; fwd_wd_i = 2; fwd_wdata_i = 7;
        step();
        inst_valid_i = 0;
        #1;
        chk("sub_reg2_fwd", reg2_o, 7);
        chk("sub_imm10", 32'(imm_o[10]), 1);
        chk("sub_aluop", 32'(aluop_o), 32'h33);
        chk("sub_reg1", reg1_o, 10);
        step();
        fwd_wreg_i = 0;

        // Back-pressure: three offered, two accepted, issued in order
        out_ready_i = 0;
        inst_valid_i = 1; inst_i = I_ADDI;
        step();
        inst_i = I_SUB;
        step();
        inst_i = I_ADD0;
        #1;
        chk("bp_ready_low", 32'(inst_ready_o), 0);
        step();
        #1;
        chk("bp_ready_still_low", 32'(inst_ready_o), 0);
        chk("bp_head_first", 32'(wd_o), 5);
        inst_valid_i = 0; out_ready_i = 1;
        step();
        #1;
        chk("bp_second_wd", 32'(wd_o), 3);
        chk("bp_second_aluop", 32'(aluop_o), 32'h33);
        chk("bp_ready_back", 32'(inst_ready_o), 1);
        step();
        #1;
        chk("bp_drained", 32'(out_valid_o), 0);

        // Flush while full
        out_ready_i = 0;
        inst_valid_i = 1; inst_i = I_ADDI;
        step();
        inst_i = I_SUB;
        step();
        inst_valid_i = 0; flush_i = 1; out_ready_i = 1;
        step();
        flush_i = 0;
        #1;
        chk("flush_valid", 32'(out_valid_o), 0);
        chk("flush_ready", 32'(inst_ready_o), 1);
        step();
        #1;
        chk("flush_no_skid", 32'(out_valid_o), 0);

        // Illegal word and write to x0
        inst_valid_i = 1; inst_i = 32'h0;
        step();
        inst_valid_i = 0;
        #1;
        chk("zero_aluop", 32'(aluop_o), 0);
        chk("zero_wreg", 32'(wreg_o), 0);
        chk("zero_illegal", 32'(illegal_o), 32'(TRAP));
        step();
        inst_valid_i = 1; inst_i = I_ADD0;
        step();
        inst_valid_i = 0;
        #1;
        chk("x0_wreg", 32'(wreg_o), 0);
        chk("x0_illegal", 32'(illegal_o), 0);
        chk("x0_imm", imm_o, 1);
        step();

        // Reset mid-operation drops buffered entries
        out_ready_i = 0;
        inst_valid_i = 1; inst_i = I_ADDI;
        step();
        rst = 1; inst_i = I_SUB;
        step();
        rst = 0; inst_valid_i = 0;
        #1;
        chk("midrst_valid", 32'(out_valid_o), 0);
        chk("midrst_ready", 32'(inst_ready_o), 1);

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            step();
            inst_valid_i = ($urandom_range(0, 3) != 0);
            inst_i       = rand_inst();
            out_ready_i  = ($urandom_range(0, 2) != 0);
            flush_i      = ($urandom_range(0, 39) == 0);
            rst          = ($urandom_range(0, 149) == 0);
            fwd_wreg_i   = 1'($urandom);
            fwd_wd_i     = 5'($urandom_range(0, 7));
            fwd_wdata_i  = $urandom;
        end
        step();
        rst = 0; flush_i = 0; inst_valid_i = 0;
        step();
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
